// File: rtl/instruction_memory_responder.sv
// Slave side of the SYN/ACK instruction fetch interface: latches a request, waits LATENCY cycles,
// then returns one word with a one-cycle ack. A side write port loads the word store.
module instruction_memory_responder #(
  parameter int unsigned        IWIDTH       = 32,
  parameter int unsigned        AWIDTH_INSTR = 32,
  parameter int unsigned        DEPTH        = 1024,
  parameter int unsigned        LATENCY      = 1,
  parameter string              INIT_FILE    = "",
  parameter logic [IWIDTH-1:0]  NOP          = IWIDTH'(32'h00000013)
) (
  input  logic                    f_clk,
  input  logic                    f_rst,
  input  logic                    m_i_syn,
  input  logic [AWIDTH_INSTR-1:0] m_i_addr,
  output logic                    m_o_ack,
  output logic [IWIDTH-1:0]       m_o_instr,
  output logic                    m_o_err,
  output logic                    m_o_busy,
  input  logic                    m_i_wr_en,
  input  logic [AWIDTH_INSTR-1:0] m_i_wr_addr,
  input  logic [IWIDTH-1:0]       m_i_wr_data
);

  localparam int unsigned IdxW   = AWIDTH_INSTR - 2;
  localparam int unsigned MemAw  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  CntInit = 4'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StAck} state_e;

  state_e                  r_state, w_state_next;
  logic [3:0]              r_cnt, w_cnt_next;
  logic [AWIDTH_INSTR-1:0] r_addr, w_addr_next;
  logic [IWIDTH-1:0]       r_instr, w_instr_next;
  logic                    r_err, w_err_next;
  logic                    w_load;

  logic [IWIDTH-1:0]       r_mem [DEPTH];

  // In IDLE the response may be registered on the sampling edge itself (LATENCY==1),
  // so the live request address is used there instead of the latched one.
  logic [AWIDTH_INSTR-1:0] w_rsp_addr;
  logic [IdxW-1:0]         w_rsp_idx;
  logic                    w_rsp_bad;
  logic [IWIDTH-1:0]       w_rsp_word;

  assign w_rsp_addr = (r_state == StIdle) ? m_i_addr : r_addr;
  assign w_rsp_idx  = w_rsp_addr[AWIDTH_INSTR-1:2];
  assign w_rsp_bad  = (w_rsp_addr[1:0] != 2'b00) || (w_rsp_idx >= IdxW'(DEPTH));
  assign w_rsp_word = w_rsp_bad ? NOP : r_mem[w_rsp_idx[MemAw-1:0]];

  logic [IdxW-1:0] w_wr_idx;
  logic            w_wr_ok;

  assign w_wr_idx = m_i_wr_addr[AWIDTH_INSTR-1:2];
  assign w_wr_ok  = m_i_wr_en && (m_i_wr_addr[1:0] == 2'b00) && (w_wr_idx < IdxW'(DEPTH));

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_addr_next  = r_addr;
    w_load       = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (m_i_syn) begin
          w_addr_next = m_i_addr;
          w_cnt_next  = CntInit;
          if (LATENCY == 1) begin
            w_state_next = StAck;
            w_load       = 1'b1;
          end else begin
            w_state_next = StBusy;
          end
        end
      end
      StBusy: begin
        w_cnt_next = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_state_next = StAck;
          w_load       = 1'b1;
        end
      end
      StAck: begin
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  always_comb begin
    w_instr_next = r_instr;
    w_err_next   = r_err;
    if (w_load) begin
      w_instr_next = w_rsp_word;
      w_err_next   = w_rsp_bad;
    end
  end

  always_ff @(posedge f_clk or negedge f_rst) begin
    if (!f_rst) begin
      r_state <= StIdle;
      r_cnt   <= 4'd0;
      r_addr  <= '0;
      r_instr <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_addr  <= w_addr_next;
      r_instr <= w_instr_next;
      r_err   <= w_err_next;
    end
  end

  // Store is not reset; a same-edge write is seen by the response only on a later edge.
  always_ff @(posedge f_clk) begin
    if (w_wr_ok) begin
      r_mem[w_wr_idx[MemAw-1:0]] <= m_i_wr_data;
    end
  end

  assign m_o_ack   = (r_state == StAck);
  assign m_o_busy  = (r_state != StIdle);
  assign m_o_instr = r_instr;
  assign m_o_err   = r_err;

endmodule
